// File: rtl/uart_wb_cmd_bridge.sv
// -----------------------------------------------------------------------------
// uart_wb_cmd_bridge
// Byte-stream command bridge from a UART RX/TX pair to a pipelined Wishbone
// master port. It parses 'W' (0x57) and 'R' (0x52) commands from RX bytes and
// issues one Wishbone request per command, honouring stall. Read-ack data goes
// into a response FIFO and is sent to the UART TX MSB first, honouring busy.
// A credit counter (requests issued but not yet fully answered) is limited to
// RESP_DEPTH, so the response FIFO can never overflow.
//
// Ports:
//   i_controller_clk, i_rst      clock, synchronous active-low reset
//   i_calib_done                 RX bytes are discarded while low
//   i_rx_valid, i_rx_data        received byte strobe/data
//   i_tx_busy, o_tx_en, o_tx_data  UART TX handshake
//   o_wb_*, i_wb_*               Wishbone master (pipelined, aux tag = we)
//   o_err                        sticky: timeout, ack without credit, bad opcode
//
// Optional build macro WRITE_ACK_ECHO_EN: each write ack queues a marker entry
// that is sent as the single byte 0x4B ('K'); the write's credit is released
// when that byte is strobed out instead of at the ack.
// -----------------------------------------------------------------------------
module uart_wb_cmd_bridge #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int RESP_DEPTH = 16,
  parameter int RX_TIMEOUT = 833333
) (
  input  logic                    i_controller_clk,
  input  logic                    i_rst,
  input  logic                    i_calib_done,
  input  logic                    i_rx_valid,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_tx_busy,
  output logic                    o_tx_en,
  output logic [7:0]              o_tx_data,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [8*ADDR_BYTES-1:0] o_wb_addr,
  output logic [8*DATA_BYTES-1:0] o_wb_data,
  output logic [DATA_BYTES-1:0]   o_wb_sel,
  output logic [3:0]              o_wb_aux,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [8*DATA_BYTES-1:0] i_wb_data,
  input  logic [3:0]              i_wb_aux,
  output logic                    o_err
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int FW = DW + 1;                 // data word plus echo-marker bit
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int BW = $clog2(ADDR_BYTES + DATA_BYTES + 1);
  localparam int LW = $clog2(DATA_BYTES + 1);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);
`ifdef WRITE_ACK_ECHO_EN
  localparam logic ECHO = 1'b1;
`else
  localparam logic ECHO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ISSUE} state_t;

  state_t          state_q;
  logic            cyc_q, stb_q, we_q, err_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   credits_q, credits_d;
  logic [TW-1:0]   timer_q;
  logic [BW-1:0]   cnt_q;

  logic [FW-1:0]   mem_q [RESP_DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q;
  logic            fifo_empty_s;
  logic [FW-1:0]   fifo_rd_s;

  logic            tx_en_q, mark_q, mark_s;
  logic [7:0]      tx_data_q;
  logic [DW-1:0]   sh_q, word_s;
  logic [LW-1:0]   left_q, n_s;

  logic rx_ok_s, credit_free_s, accept_s;
  logic ack_ok_s, ack_err_s, push_s, push_mark_s, rel_ack_s;
  logic pop_s, fire_s, rel_tx_s;
  logic unused_aux_s;

  assign rx_ok_s       = i_rx_valid && i_calib_done;
  assign credit_free_s = credits_q < CW'(RESP_DEPTH);
  assign fifo_empty_s  = (wr_ptr_q == rd_ptr_q);
  assign fifo_rd_s     = mem_q[rd_ptr_q[PW-1:0]];
  assign unused_aux_s  = ^i_wb_aux[3:1];

  // Ack classification and net credit update (issue and release may coincide).
  always_comb begin
    ack_ok_s    = i_wb_ack && (credits_q != '0);
    ack_err_s   = i_wb_ack && (credits_q == '0);
    push_s      = ack_ok_s && (!i_wb_aux[0] || ECHO);
    push_mark_s = ack_ok_s && i_wb_aux[0] && ECHO;
    rel_ack_s   = ack_ok_s && i_wb_aux[0] && !ECHO;
    accept_s    = stb_q && !i_wb_stall;
    credits_d   = credits_q + CW'(accept_s) - CW'(rel_ack_s) - CW'(rel_tx_s);
  end

  // Command parser FSM with registered Wishbone request and credit counter.
  always_ff @(posedge i_controller_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b1;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      credits_q <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
    end else begin
      credits_q <= credits_d;
      if (ack_err_s) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rx_ok_s) begin
            if (i_rx_data == 8'h57 || i_rx_data == 8'h52) begin
              we_q    <= (i_rx_data == 8'h57);
              cnt_q   <= '0;
              timer_q <= '0;
              state_q <= S_ADDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_ok_s) begin
            timer_q <= '0;
            if (state_q == S_ADDR) begin
              addr_q <= (addr_q << 8) | AW'(i_rx_data);
              if (cnt_q == BW'(ADDR_BYTES - 1)) begin
                cnt_q <= '0;
                if (we_q) begin
                  state_q <= S_DATA;
                end else begin
                  state_q <= S_ISSUE;
                  stb_q   <= credit_free_s;
                end
              end else begin
                cnt_q <= cnt_q + BW'(1);
              end
            end else begin
              wdata_q <= (wdata_q << 8) | DW'(i_rx_data);
              if (cnt_q == BW'(DATA_BYTES - 1)) begin
                cnt_q   <= '0;
                state_q <= S_ISSUE;
                stb_q   <= credit_free_s;
              end else begin
                cnt_q <= cnt_q + BW'(1);
              end
            end
          end else if (timer_q == TW'(RX_TIMEOUT - 1)) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_ISSUE: begin
          // ISSUE with stb low means the command is complete but waiting for credit.
          if (stb_q) begin
            if (!i_wb_stall) begin
              stb_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (credit_free_s) begin
            stb_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Response FIFO pointers; the credit limit guarantees no overflow.
  always_ff @(posedge i_controller_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Response FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge i_controller_clk) begin
    if (push_s) mem_q[wr_ptr_q[PW-1:0]] <= {push_mark_s, i_wb_data};
  end

  // Serialiser next word: popping and sending the first byte share one cycle,
  // which gives the two-cycle ack-to-first-byte latency.
  always_comb begin
    pop_s  = 1'b0;
    word_s = sh_q;
    mark_s = mark_q;
    n_s    = left_q;
    if (left_q == '0) begin
      if (!fifo_empty_s) begin
        pop_s  = 1'b1;
        word_s = fifo_rd_s[DW-1:0];
        mark_s = fifo_rd_s[DW];
        n_s    = fifo_rd_s[DW] ? LW'(1) : LW'(DATA_BYTES);
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
    fire_s   = (n_s != '0) && !i_tx_busy && !tx_en_q;
    rel_tx_s = fire_s && (n_s == LW'(1));
  end

  // Serialiser registers: one-cycle tx strobe, MSB-first shift.
  always_ff @(posedge i_controller_clk) begin
    if (!i_rst) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      sh_q      <= '0;
      left_q    <= '0;
      mark_q    <= 1'b0;
    end else if (fire_s) begin
      tx_en_q   <= 1'b1;
      tx_data_q <= mark_s ? 8'h4B : word_s[DW-1 -: 8];
      sh_q      <= word_s << 8;
      left_q    <= n_s - LW'(1);
      mark_q    <= mark_s;
    end else begin
      tx_en_q <= 1'b0;
      sh_q    <= word_s;
      left_q  <= n_s;
      mark_q  <= mark_s;
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign o_wb_sel  = '1;
  assign o_wb_aux  = {3'b000, we_q};
  assign o_err     = err_q;
  assign o_tx_en   = tx_en_q;
  assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_wb_cmd_bridge.sv
// Bench for uart_wb_cmd_bridge. A transaction-level model (expected request
// queue, memory model behind an auto-acking Wishbone responder, expected TX
// byte queue, credit count) is checked by one compare process on the falling
// edge; directed steps add hand-computed literal checks.
module tb_uart_wb_cmd_bridge;
  localparam int TO = 40;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        i_rst, i_calib_done, i_rx_valid, i_tx_busy;
  logic [7:0]  i_rx_data;
  logic        o_tx_en;
  logic [7:0]  o_tx_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, o_err;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel, o_wb_aux;
  logic        i_wb_stall, i_wb_ack;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_aux;

  always #5 clk = ~clk;

  uart_wb_cmd_bridge #(.ADDR_BYTES(4), .DATA_BYTES(4), .RESP_DEPTH(DEPTH), .RX_TIMEOUT(TO)) dut (
    .i_controller_clk(clk), .i_rst(i_rst), .i_calib_done(i_calib_done),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_tx_busy(i_tx_busy),
    .o_tx_en(o_tx_en), .o_tx_data(o_tx_data), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .o_wb_aux(o_wb_aux), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .i_wb_aux(i_wb_aux), .o_err(o_err));

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct {logic [7:0] b; bit last; bit first_rd;} txb_t;

  int n_checks = 0, n_errors = 0;
  req_t exp_req[$], ack_q[$], acc_log[$];
  txb_t exp_tx[$];
  logic [7:0] tx_log[$];
  logic [31:0] mem [logic [31:0]];
  int model_credit = 0, n_acc = 0, n_tx = 0, cyc_cnt = 0;
  int stb_rise_cyc = 0, last_byte_cyc = 0, rd_ack_cyc = 0, first_tx_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unwritten addresses read back a pattern derived from the address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  // Wishbone responder: acks each accepted request one cycle later, in order.
  initial begin
    req_t r;
    logic [31:0] d;
    i_wb_ack = 1'b0; i_wb_aux = 4'h0; i_wb_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      i_wb_ack = 1'b0; i_wb_aux = 4'h0; i_wb_data = 32'h0;
      if (i_rst && ack_q.size() > 0) begin
        r = ack_q.pop_front();
        i_wb_ack = 1'b1;
        i_wb_aux = {3'b000, r.we};
        if (r.we) begin
          mem[r.addr] = r.data;
`ifdef WRITE_ACK_ECHO_EN
          exp_tx.push_back('{8'h4B, 1'b1, 1'b0});
`else
          model_credit--;
`endif
        end else begin
          d = rd_val(r.addr);
          i_wb_data = d;
          rd_ack_cyc = cyc_cnt;
          for (int i = 0; i < 4; i++) exp_tx.push_back('{d[31-8*i -: 8], i == 3, i == 0});
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every cycle.
  initial begin
    req_t r, it;
    txb_t e;
    logic p_stb = 1'b0, p_stall = 1'b0, p_tx_en = 1'b0, p_busy = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        p_stb = 1'b0; p_stall = 1'b0; p_tx_en = 1'b0; p_busy = 1'b0;
      end else begin
        if (o_tx_en) begin
          chk("tx_spacing", {p_tx_en, p_busy}, 2'b00);
          if (exp_tx.size() == 0) begin
            chk("tx_unexpected_byte", {1'b1, o_tx_data}, 9'h000);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", o_tx_data, e.b);
            if (e.last) model_credit--;
            if (e.first_rd) first_tx_cyc = cyc_cnt;
          end
          tx_log.push_back(o_tx_data);
          n_tx++;
        end
        if (p_stb && p_stall) begin
          chk("stall_hold_stb", o_wb_stb, 1'b1);
          chk("stall_hold_req", {o_wb_we, o_wb_addr, o_wb_data}, {p_we, p_addr, p_data});
        end
        if (o_wb_stb && !p_stb) stb_rise_cyc = cyc_cnt;
        if (o_wb_stb) begin
          chk("wb_aux", o_wb_aux, {3'b000, o_wb_we});
          chk("wb_sel", o_wb_sel, 4'hF);
          chk("wb_cyc", o_wb_cyc, 1'b1);
        end
        if (o_wb_stb && !i_wb_stall) begin
          chk("credit_limit", model_credit < DEPTH, 1'b1);
          if (exp_req.size() == 0) begin
            chk("unexpected_request", {o_wb_we, o_wb_addr}, 33'h1_FFFF_FFFF);
          end else begin
            r = exp_req.pop_front();
            chk("req_we", o_wb_we, r.we);
            chk("req_addr", o_wb_addr, r.addr);
            if (r.we) chk("req_data", o_wb_data, r.data);
          end
          it = '{o_wb_we, o_wb_addr, o_wb_data};
          ack_q.push_back(it);
          acc_log.push_back(it);
          model_credit++;
          n_acc++;
        end
        p_stb = o_wb_stb; p_stall = i_wb_stall; p_tx_en = o_tx_en; p_busy = i_tx_busy;
        p_we = o_wb_we; p_addr = o_wb_addr; p_data = o_wb_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1; i_rx_data = b; last_byte_cyc = cyc_cnt;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    for (int k = 0; k < 400; k++) begin
      if (n_acc >= target) break;
      @(posedge clk); #1;
    end
    chk("accept_timeout", n_acc >= target, 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a, input bit wt);
    int t;
    t = n_acc + 1;
    exp_req.push_back('{1'b0, a, 32'h0});
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
    if (wt) wait_acc(t);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    int t;
    t = n_acc + 1;
    exp_req.push_back('{1'b1, a, d});
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
    wait_acc(t);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_tx.size() == 0 && ack_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("drain_tx_left", exp_tx.size(), 0);
  endtask

  task automatic reset_dut();
    i_rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_ctrl", {o_wb_stb, o_wb_we, o_err, o_tx_en, o_wb_cyc}, 5'b00001);
    chk("rst_addr_data", {o_wb_addr, o_wb_data}, 64'h0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    exp_req.delete(); ack_q.delete(); exp_tx.delete();
    model_credit = 0;
    i_rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, tx0;
    logic [7:0] t1_exp[$];
    i_rst = 1'b0; i_calib_done = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    i_tx_busy = 1'b0; i_wb_stall = 1'b0;
    @(posedge clk); #1;
    reset_dut();
    i_calib_done = 1'b1;

    // 1: write then read back through the UART TX.
    send_write(32'h10, 32'hDEADBEEF);
    send_read(32'h10, 1'b1);
    chk("t1_rd_issue_latency", stb_rise_cyc - last_byte_cyc, 1);
    drain(200);
    chk("t1_wr_req", {acc_log[0].we, acc_log[0].addr, acc_log[0].data}, {1'b1, 32'h10, 32'hDEADBEEF});
    chk("t1_rd_req", {acc_log[1].we, acc_log[1].addr}, {1'b0, 32'h10});
`ifdef WRITE_ACK_ECHO_EN
    t1_exp = '{8'h4B, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`else
    t1_exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
`endif
    chk("t1_tx_count", tx_log.size(), t1_exp.size());
    for (int i = 0; i < t1_exp.size() && i < tx_log.size(); i++) chk("t1_tx_seq", tx_log[i], t1_exp[i]);
    chk("t1_ack_to_tx_latency", first_tx_cyc - rd_ack_cyc, 2);
    chk("t1_err", o_err, 1'b0);

    // Idle gap of TO-1 cycles between command bytes is still accepted.
    n0 = n_acc;
    exp_req.push_back('{1'b0, 32'h20, 32'h0});
    send_byte(8'h52); send_byte(8'h00);
    repeat (TO - 1) begin @(posedge clk); #1; end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    wait_acc(n0 + 1);
    drain(200);
    chk("gap_err", o_err, 1'b0);

    // 2: request held stable through 5 stalled cycles.
    n0 = n_acc;
    i_wb_stall = 1'b1;
    send_read(32'h30, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (o_wb_stb) break;
      @(posedge clk); #1;
    end
    chk("t2_stb_seen", o_wb_stb, 1'b1);
    repeat (4) begin @(posedge clk); #1; chk("t2_stb_held", o_wb_stb, 1'b1); end
    chk("t2_no_accept_while_stalled", n_acc - n0, 0);
    i_wb_stall = 1'b0;
    @(posedge clk); #1;
    chk("t2_one_accept", n_acc - n0, 1);
    chk("t2_stb_dropped", o_wb_stb, 1'b0);
    drain(200);

    // 3: TX busy, credit limit stops issuing after DEPTH reads.
    n0 = n_acc; tx0 = n_tx;
    i_tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) send_read(32'h100 + i, 1'b1);
    send_read(32'h100 + DEPTH, 1'b0);
    repeat (30) begin @(posedge clk); #1; end
    chk("t3_issue_blocked", n_acc - n0, DEPTH);
    chk("t3_no_tx_while_busy", n_tx - tx0, 0);
    i_tx_busy = 1'b0;
    wait_acc(n0 + DEPTH + 1);
    chk("t3_word_sent_before_17th", (n_tx - tx0) >= 4, 1'b1);
    for (int i = DEPTH + 1; i < 20; i++) send_read(32'h100 + i, 1'b1);
    drain(800);
    chk("t3_accepts", n_acc - n0, 20);
    chk("t3_tx_bytes", n_tx - tx0, 80);
    chk("t3_first_byte", tx_log[tx0], 8'hFE);

    // 4: truncated command times out.
    n0 = n_acc;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    repeat (TO + 1) begin @(posedge clk); #1; end
    chk("t4_err", o_err, 1'b1);
    chk("t4_no_request", n_acc - n0, 0);
    send_read(32'h44, 1'b1);
    drain(200);

    // 5: calib-low bytes ignored, bad opcode, reset mid-address.
    reset_dut();
    n0 = n_acc;
    i_calib_done = 1'b0;
    send_byte(8'h41); send_byte(8'h57);
    i_calib_done = 1'b1;
    @(posedge clk); #1;
    chk("t5_calib_low_ignored", o_err, 1'b0);
    send_byte(8'h41);
    chk("t5_bad_opcode_err", o_err, 1'b1);
    chk("t5_no_request", n_acc - n0, 0);
    send_byte(8'h52); send_byte(8'h00);
    reset_dut();
    send_read(32'h55, 1'b1);
    drain(200);

    // 6: write ack echo (or silence).
    tx0 = n_tx;
    send_write(32'h60, 32'h12345678);
    repeat (20) begin @(posedge clk); #1; end
`ifdef WRITE_ACK_ECHO_EN
    chk("t6_echo_count", n_tx - tx0, 1);
    chk("t6_echo_byte", tx_log[tx_log.size() - 1], 8'h4B);
`else
    chk("t6_silent_write", n_tx - tx0, 0);
`endif
    send_read(32'h60, 1'b1);
    drain(200);
    chk("final_err", o_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
